piso_serial_ctrl: RTL and testbench
===================================

// Module: piso_serial_ctrl
// PURPOSE
//   Sequencing controller for a parallel-in/serial-out shifter. Accepts parallel
//   words over a valid/ready handshake, then shifts each word out MSB-first.
//   Each bit is held for BIT_DIV clocks. Frame and completion status are driven
//   for downstream serial sinks. An optional inter-frame gap is inserted.
//   Sits between a word producer and a 1-bit serial link; the shift register is
//   internal to this block.
// PARAMETERS
//   WIDTH      4  bits per word (>=2)
//   BIT_DIV    1  clocks each bit is held on sout (>=1)
//   GAP_CYCLES 1  idle clocks after each frame before ready returns (>=0)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   in_data    in   WIDTH  parallel word to serialise
//   in_valid   in   1      producer has a word
//   in_ready   out  1      block can accept a word (IDLE only)
//   abort      in   1      cancel current frame (SHIFT/GAP only)
//   sout       out  1      serial data, MSB first; 0 when sout_valid=0
//   sout_valid out  1      sout carries a frame bit
//   busy       out  1      state != IDLE
//   done       out  1      1-cycle pulse in final clock of last bit
// BEHAVIOUR
//   Reset (sync, highest priority): state=IDLE; shift_reg, bit_cnt and div_cnt
//     are cleared. Outputs after reset: in_ready=1, sout=0, sout_valid=0,
//     busy=0, done=0.
//   FSM states: IDLE, SHIFT, GAP.
//   IDLE: in_ready=1. When in_valid=1 in cycle N, the word is accepted:
//     shift_reg<=in_data, bit_cnt<=0, div_cnt<=0, and the next state is SHIFT.
//     abort is ignored in IDLE, so in_valid together with abort still accepts.
//   SHIFT: sout=shift_reg[WIDTH-1] and sout_valid=1.
//     Latency: the first bit appears in cycle N+1.
//     div_cnt counts 0..BIT_DIV-1. On wrap, shift_reg shifts left (zero fill)
//     and bit_cnt increments.
//     Last bit: bit_cnt==WIDTH-1 and div_cnt==BIT_DIV-1. In that cycle done=1,
//     and the next state is GAP, or IDLE if GAP_CYCLES==0.
//     Frame length is exactly WIDTH*BIT_DIV cycles.
//   GAP: sout_valid=0 and in_ready=0. After GAP_CYCLES cycles the next state
//     is IDLE.
//   abort in SHIFT or GAP: next state is IDLE. sout_valid drops the next cycle.
//     No done pulse. The word is discarded and the counters are cleared.
//     abort in the last-bit cycle: abort wins and done is suppressed.
//   in_ready is combinational from state (no in_valid dependency). in_data is
//     sampled only on the accept cycle.
//   Back-to-back throughput: one word per WIDTH*BIT_DIV + GAP_CYCLES + 1 clocks.
//   Counter widths: bit_cnt and div_cnt are sized $clog2(max)+1 with no
//     overflow. Counters wrap only at the defined terminal values.
// TESTING (WIDTH=4 unless stated)
//   1 Basic frame (BIT_DIV=1, GAP=1):
//     in_data=4'b1011 accepted at N -> sout=1,0,1,1 on N+1..N+4;
//     done=1 only at N+4; GAP at N+5; in_ready=1 at N+6.
//   2 Clock divide (BIT_DIV=2):
//     4'b1100 -> sout=1,1,1,1,0,0,0,0 on N+1..N+8; done at N+8.
//   3 Back-to-back (GAP=0, in_valid held high):
//     words 4'hA then 4'h5 -> sout=1010 then 0101, second accepted at N+5.
//   4 Abort mid-frame: abort at the second bit -> sout_valid=0 next cycle,
//     no done, in_ready=1 next cycle. The following word serialises normally.
//   5 Reset mid-SHIFT: reset in bit 3 -> next cycle IDLE, sout=0,
//     sout_valid=0, busy=0. Abort+in_valid in IDLE still accepts the word.
//   6 Idle hold: in_valid=0 for 20 cycles -> busy=0, sout_valid=0, done never
//     asserted.

Source files
------------

// File: rtl/piso_serial_ctrl.sv
// Parallel-in/serial-out sequencer: accepts a word in IDLE, shifts it out MSB-first
// holding each bit BIT_DIV clocks, then idles GAP_CYCLES clocks before accepting again.
module piso_serial_ctrl #(
  parameter int WIDTH      = 4,
  parameter int BIT_DIV    = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam int DW = $clog2(BIT_DIV) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
  // With no gap the GAP state is unreachable, so its terminal value is irrelevant.
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic [GW-1:0]    gap_cnt;

  logic div_wrap, last_bit, gap_end;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign last_bit = (bit_cnt == BIT_LAST) && div_wrap;
  assign gap_end  = (gap_cnt == GAP_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (in_valid) next_state = SHIFT;
      SHIFT: begin
        if (abort)         next_state = IDLE;
        else if (last_bit) next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP:   if (abort || gap_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= in_data;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
          end else if (div_wrap) begin
            div_cnt   <= '0;
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            bit_cnt   <= last_bit ? '0 : bit_cnt + BW'(1);
            gap_cnt   <= '0;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        GAP: begin
          if (abort || gap_end) gap_cnt <= '0;
          else                  gap_cnt <= gap_cnt + GW'(1);
        end
        default: begin
          bit_cnt <= '0;
          div_cnt <= '0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

  // abort takes priority over completion, so done is masked in the same cycle.
  always_comb begin
    in_ready   = (state == IDLE);
    busy       = (state != IDLE);
    sout_valid = (state == SHIFT);
    sout       = (state == SHIFT) && shift_reg[WIDTH-1];
    done       = (state == SHIFT) && last_bit && !abort;
  end

endmodule

// File: tb/tb_piso_serial_ctrl.sv
// Bench for piso_serial_ctrl: three instances (div1/gap1, div2/gap1, div1/gap0)
// checked against an arithmetic model of the serial frame.
module tb_piso_serial_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0] in_data [3];
  logic in_valid [3];
  logic abort [3];
  logic in_ready [3];
  logic sout [3];
  logic sout_valid [3];
  logic busy [3];
  logic done [3];

  int checks = 0;
  int fails  = 0;

  piso_serial_ctrl #(.WIDTH(4), .BIT_DIV(1), .GAP_CYCLES(1)) u0 (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .abort(abort[0]), .sout(sout[0]),
    .sout_valid(sout_valid[0]), .busy(busy[0]), .done(done[0]));

  piso_serial_ctrl #(.WIDTH(4), .BIT_DIV(2), .GAP_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .abort(abort[1]), .sout(sout[1]),
    .sout_valid(sout_valid[1]), .busy(busy[1]), .done(done[1]));

  piso_serial_ctrl #(.WIDTH(4), .BIT_DIV(1), .GAP_CYCLES(0)) u2 (
    .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .abort(abort[2]), .sout(sout[2]),
    .sout_valid(sout_valid[2]), .busy(busy[2]), .done(done[2]));

  // Reference model: frame of 4*bd cycles starting the cycle after accept,
  // bit for cycle k (1-based) is word bit 3 - (k-1)/bd.
  function automatic int bd(int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int gap(int i);
    return (i == 2) ? 0 : 1;
  endfunction

  function automatic logic model_bit(int i, logic [3:0] w, int k);
    return w[3 - (k - 1) / bd(i)];
  endfunction

  function automatic logic [4:0] observe(int i);
    return {sout_valid[i], sout[i], done[i], in_ready[i], busy[i]};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      abort[i]    = 1'b0;
      in_data[i]  = 4'($urandom);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (observe(i) !== 5'b00010) begin
        fails++;
        $display("FAIL reset inst%0d {sv,s,done,rdy,busy} got %b expected 00010", i, observe(i));
      end
    end
  endtask

  // Several frames on instance i; the first uses the given word, the rest are random.
  task automatic test_frames(input int i, input logic [3:0] first, input int nwords);
    int len;
    logic [3:0] w;
    logic ev, es, ed, er;
    len = 4 * bd(i);
    for (int n = 0; n < nwords; n++) begin
      w = (n == 0) ? first : 4'($urandom);
      @(negedge clk);
      in_valid[i] = 1'b1;
      in_data[i]  = w;
      for (int k = 1; k <= len + gap(i) + 1; k++) begin
        @(negedge clk);
        in_valid[i] = 1'b0;
        in_data[i]  = 4'($urandom);
        ev = (k <= len);
        es = ev ? model_bit(i, w, k) : 1'b0;
        ed = (k == len);
        er = (k > len + gap(i));
        checks++;
        if (observe(i) !== {ev, es, ed, er, !er}) begin
          fails++;
          $display("FAIL frame inst%0d word %h cycle N+%0d {sv,s,done,rdy,busy} got %b expected %b",
                   i, w, k, observe(i), {ev, es, ed, er, !er});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [6];
    int ph, j;
    logic [4:0] exp_v;
    words[0] = 4'hA;
    words[1] = 4'h5;
    for (int n = 2; n < 6; n++) words[n] = 4'($urandom);
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      ph = t % 5;
      j  = t / 5;
      if (ph == 0) exp_v = 5'b00010;
      else         exp_v = {1'b1, words[j][4 - ph], (ph == 4), 1'b0, 1'b1};
      checks++;
      if (observe(2) !== exp_v) begin
        fails++;
        $display("FAIL b2b cycle N+%0d {sv,s,done,rdy,busy} got %b expected %b", t, observe(2), exp_v);
      end
      in_valid[2] = 1'b1;
      if (ph == 0) in_data[2] = words[j];
      else         in_data[2] = 4'($urandom);
    end
    in_valid[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (observe(2) !== 5'b00010) begin
      fails++;
      $display("FAIL b2b_end {sv,s,done,rdy,busy} got %b expected 00010", observe(2));
    end
  endtask

  task automatic test_abort();
    int pos;
    logic [3:0] w;
    for (int n = 0; n < 5; n++) begin
      pos = (n == 0) ? 2 : ((n == 1) ? 4 : int'($urandom_range(1, 4)));
      w = 4'($urandom);
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data[0]  = w;
      for (int k = 1; k <= pos; k++) begin
        @(negedge clk);
        in_valid[0] = 1'b0;
        checks++;
        if (observe(0) !== {1'b1, model_bit(0, w, k), (k == 4), 1'b0, 1'b1}) begin
          fails++;
          $display("FAIL abort_pre word %h bit %0d got %b expected %b",
                   w, k, observe(0), {1'b1, model_bit(0, w, k), (k == 4), 1'b0, 1'b1});
        end
      end
      abort[0] = 1'b1;
      #1;
      checks++;
      if (done[0] !== 1'b0) begin
        fails++;
        $display("FAIL abort_done_mask bit %0d done got %b expected 0", pos, done[0]);
      end
      @(negedge clk);
      checks++;
      if (observe(0) !== 5'b00010) begin
        fails++;
        $display("FAIL abort_post bit %0d {sv,s,done,rdy,busy} got %b expected 00010", pos, observe(0));
      end
      abort[0] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] w, w2;
    w  = 4'($urandom);
    w2 = 4'($urandom);
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = w;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      in_valid[0] = 1'b0;
      checks++;
      if (observe(0) !== {1'b1, model_bit(0, w, k), 1'b0, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL rstmid_pre bit %0d got %b expected %b",
                 k, observe(0), {1'b1, model_bit(0, w, k), 1'b0, 1'b0, 1'b1});
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (observe(0) !== 5'b00010) begin
      fails++;
      $display("FAIL rstmid_idle {sv,s,done,rdy,busy} got %b expected 00010", observe(0));
    end
    reset       = 1'b0;
    abort[0]    = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = w2;
    @(negedge clk);
    abort[0]    = 1'b0;
    in_valid[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (observe(0) !== {(k <= 4), (k <= 4) ? model_bit(0, w2, k) : 1'b0, (k == 4), (k == 6), (k != 6)}) begin
        fails++;
        $display("FAIL rstmid_accept word %h cycle N+%0d got %b expected %b", w2, k, observe(0),
                 {(k <= 4), (k <= 4) ? model_bit(0, w2, k) : 1'b0, (k == 4), (k == 6), (k != 6)});
      end
    end
  endtask

  task automatic test_idle_hold();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        in_valid[i] = 1'b0;
        in_data[i]  = 4'($urandom);
        checks++;
        if (observe(i) !== 5'b00010) begin
          fails++;
          $display("FAIL idle inst%0d cycle %0d got %b expected 00010", i, c, observe(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames(0, 4'b1011, 5);
    test_frames(1, 4'b1100, 4);
    test_back_to_back();
    test_abort();
    test_frames(0, 4'($urandom), 2);
    test_reset_mid();
    test_idle_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
